// File: rtl/vga_timing_gen.sv
// VGA timing generator: one pixel every two clk, counters exposed as x/y, and
// DAC outputs (RGB, sync, blank) registered one pixel period behind x/y.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_clk,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       r_tick;
  logic [9:0] r_h, r_v;
  logic [7:0] r_r, r_g, r_b;
  logic       r_hs, r_vs, r_blank_n, r_fs;

  logic w_h_last, w_v_last, w_active, w_hs_n, w_vs_n;

  // >= rather than == so a corrupted counter still falls back into range
  assign w_h_last = (r_h >= H_LAST);
  assign w_v_last = (r_v >= V_LAST);
  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_n   = !((r_h >= HS_START) && (r_h < HS_END));
  assign w_vs_n   = !((r_v >= VS_START) && (r_v < VS_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick    <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      r_fs   <= 1'b0;
      // Pixel edge: everything below is sampled from pre-increment counters
      if (r_tick) begin
        r_h <= w_h_last ? '0 : r_h + 10'd1;
        if (w_h_last) r_v <= w_v_last ? '0 : r_v + 10'd1;
        r_fs      <= w_h_last && w_v_last;
        r_r       <= w_active ? red   : 8'd0;
        r_g       <= w_active ? green : 8'd0;
        r_b       <= w_active ? blue  : 8'd0;
        r_blank_n <= w_active;
        r_hs      <= w_hs_n;
        r_vs      <= w_vs_n;
      end
    end
  end

  assign x           = r_h;
  assign y           = r_v;
  assign vga_r       = r_r;
  assign vga_g       = r_g;
  assign vga_b       = r_b;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign vga_clk     = r_tick;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a shrunken raster so several
// frames fit in a short run; expected outputs come from the pixel index.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 4, HSW = 6, HBP = 4;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME_CLK = 2 * HT * VT;

  typedef struct packed {
    logic [9:0] x, y;
    logic [7:0] r, g, b;
    logic       hs, vs, blank, vclk, fs;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x, y;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start;

  int   checks = 0, errors = 0;
  obs_t exp_q[$];
  bit   mode_ff = 1'b1;
  logic [7:0] kr = '0, kg = '0, kb = '0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .red(red), .green(green), .blue(blue),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_clk(vga_clk), .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  function automatic obs_t rst_vals();
    obs_t e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  // c = clk edges seen since reset release; pixel index p = c/2
  function automatic obs_t model(int c);
    obs_t e;
    int p, q, qx, qy;
    bit act;
    e = rst_vals();
    if (c == 0) return e;
    p = c / 2;
    e.x    = 10'(p % HT);
    e.y    = 10'((p / HT) % VT);
    e.vclk = 1'(c % 2);
    if (p >= 1) begin
      q  = p - 1;
      qx = q % HT;
      qy = (q / HT) % VT;
      act     = (qx < HA) && (qy < VA);
      e.blank = act;
      e.hs    = !((qx >= HA + HFP) && (qx < HA + HFP + HSW));
      e.vs    = !((qy >= VA + VFP) && (qy < VA + VFP + VSW));
      if (act) begin
        e.r = mode_ff ? 8'hFF : 8'(qx) ^ kr;
        e.g = mode_ff ? 8'hFF : 8'(qy) ^ kg;
        e.b = mode_ff ? 8'hFF : 8'(qx + qy) ^ kb;
      end
      e.fs = (c % 2 == 0) && (p % (HT * VT) == 0);
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{x, y, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start};
    return o;
  endfunction

  // Pixel source: registered function of x/y, updated mid-cycle
  initial forever begin
    @(negedge clk);
    red   = mode_ff ? 8'hFF : x[7:0] ^ kr;
    green = mode_ff ? 8'hFF : y[7:0] ^ kg;
    blue  = mode_ff ? 8'hFF : 8'(x + y) ^ kb;
  end

  // Stimulus side of the scoreboard: expected state after every edge
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) c = 0;
      else c++;
      exp_q.push_back(model(c));
    end
  end

  // Monitor: compare DUT against queued expectation away from the edge
  initial forever begin
    obs_t e, g;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL dac_state t=%0t got x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b bl=%b vc=%b fs=%b exp x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b bl=%b vc=%b fs=%b",
                 $time, g.x, g.y, g.r, g.g, g.b, g.hs, g.vs, g.blank, g.vclk, g.fs,
                 e.x, e.y, e.r, e.g, e.b, e.hs, e.vs, e.blank, e.vclk, e.fs);
      end
    end
  end

  task automatic do_reset(input bit ff);
    obs_t g;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    g = sample();
    checks++;
    if (g !== rst_vals()) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", g, rst_vals());
    end
    mode_ff = ff;
    kr = 8'($urandom);
    kg = 8'($urandom);
    kb = 8'($urandom);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * FRAME_CLK + 40) @(negedge clk);
    do_reset(1'b0);
    repeat ($urandom_range(FRAME_CLK / 3, FRAME_CLK - 10)) @(negedge clk);
    do_reset(1'b0);
    repeat (2 * FRAME_CLK + 20) @(negedge clk);
    do_reset(1'b1);
    repeat ($urandom_range(50, FRAME_CLK)) @(negedge clk);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters, one per line, as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)

REQ-002 SHALL have ports, one per line, as name, direction, width, meaning:
- clk, input, 1, single system clock, 50 MHz
- rst_n, input, 1, asynchronous active-low reset
- x, output, 10, current horizontal counter, driven to the pixel source
- y, output, 10, current vertical counter, driven to the pixel source
- red, input, 8, pixel-source red; must be valid one clk after x/y change
- green, input, 8, pixel-source green
- blue, input, 8, pixel-source blue
- vga_r, output, 8, registered red to DAC
- vga_g, output, 8, registered green to DAC
- vga_b, output, 8, registered blue to DAC
- vga_hs, output, 1, horizontal sync, active low
- vga_vs, output, 1, vertical sync, active low
- vga_blank_n, output, 1, high during the visible region
- vga_clk, output, 1, 25 MHz pixel clock to DAC
- frame_start, output, 1, one-clk pulse at each frame origin

Function
REQ-003 SHALL hold an internal 1-bit tick toggling every clk (0 on first clk after reset release); pixel period = 2 clk.
REQ-004 SHALL drive vga_clk = tick, so vga_clk rises one clk after every output update.
REQ-005 SHALL, on clk edges with tick=1 only, advance h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800) and wrap to 0.
REQ-006 SHALL, on the same edge where h_cnt wraps, advance v_cnt 0..V_TOTAL-1 (V_TOTAL = 525) and wrap to 0; h and v wrap simultaneously at (799,524) -> (0,0).
REQ-007 SHALL drive x = h_cnt and y = v_cnt directly from registers, unclamped (0..799, 0..524).
REQ-008 SHALL define active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE), evaluated on pre-increment counter values.
REQ-009 SHALL register, on tick=1 edges, vga_r/g/b <= active ? red/green/blue : 0; the source has had one clk since x/y changed.
REQ-010 SHALL register, on the same edges, vga_blank_n <= active; vga_hs <= 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); vga_vs <= 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-011 SHALL thereby delay all DAC outputs by exactly one pixel period (2 clk) relative to x/y, with RGB, sync and blank mutually aligned.
REQ-012 SHALL assert frame_start for exactly one clk, on the edge where counters wrap to (0,0), and deassert it on the next edge.
REQ-013 SHALL keep all outputs unchanged on tick=0 edges, except frame_start clearing.
REQ-014 SHALL use 10-bit counters; no value outside the ranges in REQ-005/006 SHALL be reachable.

Reset
REQ-015 SHALL, while rst_n=0 and independent of clk, force: tick=0, h_cnt=0, v_cnt=0, x=0, y=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_start=0, vga_clk=0.
REQ-016 SHALL, on assertion mid-frame, abort the frame; after release, restart from (0,0) with no frame_start pulse until the first wrap.

Verification
REQ-017 Reset values: assert rst_n=0 mid-line -> all REQ-015 values immediately, without a clk edge; release -> x=1 after 2 clk edges.
REQ-018 Hsync timing: free-run one line -> vga_hs low for 192 consecutive clk, first low edge 2 clk after x becomes 656; line period 1600 clk.
REQ-019 Frame period: run two frames -> frame_start pulses exactly 840000 clk apart, each 1 clk wide, coincident with x=0, y=0; vga_vs low for 3200 clk per frame.
REQ-020 Pipeline alignment: model the source as red = x[7:0] registered one clk -> whenever vga_blank_n=1, vga_r equals the x value from one pixel earlier (e.g. x=5 -> vga_r=5 two clk later).
REQ-021 Blanking: hold red=green=blue=8'hFF -> vga_r/g/b=0 whenever x>=640 or y>=480 at sample time; 8'hFF inside the active region.
REQ-022 Mid-frame reset: pulse rst_n low at x=300, y=200 -> counters return to (0,0); the next frame_start occurs 840000 clk after release.
